// File: rtl/fault_dict_lookup.sv
// Fault-dictionary diagnosis: captures an observed pass/fail syndrome, then streams dictionary entries
// reporting exact matches. Optional nearest-match tracking is enabled with macro FAULT_DICT_NEAREST_EN.
module fault_dict_lookup #(
    parameter int NTEST = 117,
    parameter int IDXW  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             obs_valid,
    input  logic             obs_fail,
    output logic             obs_ready,
    input  logic             dct_valid,
    input  logic [NTEST-1:0] dct_syn,
    input  logic             dct_last,
    output logic             dct_ready,
    output logic             match_valid,
    output logic [IDXW-1:0]  match_idx,
    input  logic             match_ready,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  match_count,
    output logic             idx_ovf
`ifdef FAULT_DICT_NEAREST_EN
    ,
    output logic [IDXW-1:0]  best_idx,
    output logic [$clog2(NTEST+1)-1:0] best_dist
`endif
);

    localparam int BCW = $clog2(NTEST + 1);
    localparam int DW  = $clog2(NTEST + 1);
    localparam logic [IDXW-1:0] IDX_MAX  = {IDXW{1'b1}};
    localparam logic [BCW-1:0]  BIT_LAST = BCW'(NTEST - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2,
        FINISH  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [NTEST-1:0] obs_q, obs_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [IDXW-1:0]  ent_q, ent_d;
    logic [IDXW-1:0]  mcnt_q, mcnt_d;
    logic             ovf_q, ovf_d;
    logic             mv_q, mv_d;
    logic [IDXW-1:0]  midx_q, midx_d;
    logic             done_q, done_d;
    logic             ent_acc_s;

`ifdef FAULT_DICT_NEAREST_EN
    logic [IDXW-1:0]  best_idx_q, best_idx_d;
    logic [DW-1:0]    best_dist_q, best_dist_d;
    logic [DW-1:0]    dist_s;

    function automatic logic [DW-1:0] popcount(input logic [NTEST-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < NTEST; i++) begin
            c = c + DW'(v[i]);
        end
        return c;
    endfunction

    assign dist_s    = popcount(dct_syn ^ obs_q);
    assign best_idx  = best_idx_q;
    assign best_dist = best_dist_q;
`endif

    // Handshake decodes come straight from registered state so reset clears them immediately.
    assign obs_ready   = (state_q == CAPTURE);
    assign dct_ready   = (state_q == SCAN) && !mv_q;
    assign busy        = (state_q != IDLE);
    assign match_valid = mv_q;
    assign match_idx   = midx_q;
    assign done        = done_q;
    assign match_count = mcnt_q;
    assign idx_ovf     = ovf_q;
    assign ent_acc_s   = (state_q == SCAN) && dct_valid && !mv_q;

    // Next-state and datapath update for capture, scan and completion.
    always_comb begin
        state_d  = state_q;
        obs_d    = obs_q;
        bitcnt_d = bitcnt_q;
        ent_d    = ent_q;
        mcnt_d   = mcnt_q;
        ovf_d    = ovf_q;
        mv_d     = mv_q;
        midx_d   = midx_q;
        done_d   = 1'b0;
`ifdef FAULT_DICT_NEAREST_EN
        best_idx_d  = best_idx_q;
        best_dist_d = best_dist_q;
`endif
        if (mv_q && match_ready) begin
            mv_d = 1'b0;
        end else begin
            mv_d = mv_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CAPTURE;
                    obs_d    = '0;
                    bitcnt_d = '0;
                    ent_d    = '0;
                    mcnt_d   = '0;
                    ovf_d    = 1'b0;
`ifdef FAULT_DICT_NEAREST_EN
                    best_idx_d  = '0;
                    best_dist_d = DW'(NTEST);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (obs_valid) begin
                    for (int i = 0; i < NTEST; i++) begin
                        if (bitcnt_q == BCW'(i)) begin
                            obs_d[i] = obs_fail;
                        end else begin
                            obs_d[i] = obs_q[i];
                        end
                    end
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = SCAN;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end else begin
                    state_d = CAPTURE;
                end
            end
            SCAN: begin
                if (ent_acc_s) begin
                    // The counter saturates so late matches still report the last representable index.
                    if (ent_q == IDX_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        ent_d = ent_q + 1'b1;
                    end
                    if (dct_syn == obs_q) begin
                        mv_d   = 1'b1;
                        midx_d = ent_q;
                        if (mcnt_q != IDX_MAX) begin
                            mcnt_d = mcnt_q + 1'b1;
                        end else begin
                            mcnt_d = mcnt_q;
                        end
                    end else begin
                        midx_d = midx_q;
                    end
`ifdef FAULT_DICT_NEAREST_EN
                    if (dist_s < best_dist_q) begin
                        best_idx_d  = ent_q;
                        best_dist_d = dist_s;
                    end else begin
                        best_idx_d  = best_idx_q;
                    end
`endif
                    if (dct_last) begin
                        state_d = FINISH;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            FINISH: begin
                if (!mv_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FINISH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            obs_q    <= '0;
            bitcnt_q <= '0;
            ent_q    <= '0;
            mcnt_q   <= '0;
            ovf_q    <= 1'b0;
            mv_q     <= 1'b0;
            midx_q   <= '0;
            done_q   <= 1'b0;
`ifdef FAULT_DICT_NEAREST_EN
            best_idx_q  <= '0;
            best_dist_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            obs_q    <= obs_d;
            bitcnt_q <= bitcnt_d;
            ent_q    <= ent_d;
            mcnt_q   <= mcnt_d;
            ovf_q    <= ovf_d;
            mv_q     <= mv_d;
            midx_q   <= midx_d;
            done_q   <= done_d;
`ifdef FAULT_DICT_NEAREST_EN
            best_idx_q  <= best_idx_d;
            best_dist_q <= best_dist_d;
`endif
        end
    end

endmodule

// File: tb/tb_fault_dict_lookup.sv
// Scoreboard bench for fault_dict_lookup (NTEST=8, IDXW=4): directed diagnoses, match handshake
// back-pressure, index overflow, asynchronous abort and ignored control pulses.
module tb_fault_dict_lookup;

    localparam int NTEST = 8;
    localparam int IDXW  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       obs_valid = 1'b0;
    logic       obs_fail = 1'b0;
    logic       dct_valid = 1'b0;
    logic [7:0] dct_syn = 8'h00;
    logic       dct_last = 1'b0;
    logic       match_ready = 1'b1;
    logic       obs_ready, dct_ready, match_valid, busy, done, idx_ovf;
    logic [3:0] match_idx, match_count;
`ifdef FAULT_DICT_NEAREST_EN
    logic [3:0] best_idx;
    logic [3:0] best_dist;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic [7:0] obs_model = 8'h00;
    int ent_model = 0;
    int cyc;

    fault_dict_lookup #(.NTEST(NTEST), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .obs_valid(obs_valid), .obs_fail(obs_fail), .obs_ready(obs_ready),
        .dct_valid(dct_valid), .dct_syn(dct_syn), .dct_last(dct_last), .dct_ready(dct_ready),
        .match_valid(match_valid), .match_idx(match_idx), .match_ready(match_ready),
        .busy(busy), .done(done), .match_count(match_count),
`ifdef FAULT_DICT_NEAREST_EN
        .best_idx(best_idx), .best_dist(best_dist),
`endif
        .idx_ovf(idx_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted match is compared against the oldest expected index.
    always @(negedge clk) begin
        if (rst_n && match_valid && match_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL match_unexpected: got idx %0d expected none", match_idx);
            end else begin
                chk("match_idx", int'(match_idx), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        ent_model = 0;
    endtask

    task automatic send_obs(input logic [7:0] s);
        obs_model = s;
        for (int i = 0; i < 8; i++) begin
            obs_valid = 1'b1;
            obs_fail  = s[i];
            tick();
        end
        obs_valid = 1'b0;
        obs_fail  = 1'b0;
    endtask

    task automatic send_entry(input logic [7:0] s, input logic last);
        int n;
        n = 0;
        while (!dct_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL entry_timeout: got dct_ready 0 expected 1");
        end
        dct_valid = 1'b1;
        dct_syn   = s;
        dct_last  = last;
        if (s == obs_model) exp_q.push_back(ent_model);
        tick();
        dct_valid = 1'b0;
        dct_last  = 1'b0;
        if (ent_model < 15) ent_model++;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int c;
        c = 0;
        while (!done && c < 50) begin
            tick();
            c++;
        end
        chk(name, c, exp_cyc);
        tick();
        chk("done_pulse_width", int'(done), 0);
    endtask

    initial begin
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_obs_ready", int'(obs_ready), 0);
        chk("rst_match_valid", int'(match_valid), 0);
        #9;
        rst_n = 1'b1;
        tick();

        // Two exact matches, earliest-tie nearest match.
        do_start();
        chk("t23_obs_ready", int'(obs_ready), 1);
        send_obs(8'h05);
        send_entry(8'h00, 1'b0);
        send_entry(8'h05, 1'b0);
        send_entry(8'h05, 1'b1);
        wait_done("t23_done_latency", 2);
        chk("t23_match_count", int'(match_count), 2);
        chk("t23_busy", int'(busy), 0);
`ifdef FAULT_DICT_NEAREST_EN
        chk("t23_best_idx", int'(best_idx), 1);
        chk("t23_best_dist", int'(best_dist), 0);
`endif

        // No exact match.
        do_start();
        send_obs(8'h05);
        send_entry(8'hFF, 1'b0);
        send_entry(8'h04, 1'b1);
        wait_done("t24_done_latency", 1);
        chk("t24_match_count", int'(match_count), 0);
        chk("t24_idx_ovf", int'(idx_ovf), 0);
`ifdef FAULT_DICT_NEAREST_EN
        chk("t24_best_idx", int'(best_idx), 1);
        chk("t24_best_dist", int'(best_dist), 1);
`endif

        // Back-pressure on the match port.
        match_ready = 1'b0;
        do_start();
        send_obs(8'h05);
        send_entry(8'h05, 1'b0);
        dct_valid = 1'b1;
        dct_syn   = 8'h05;
        dct_last  = 1'b1;
        exp_q.push_back(1);
        for (int i = 0; i < 5; i++) begin
            chk("t25_dct_ready_low", int'(dct_ready), 0);
            chk("t25_match_idx_stable", int'(match_idx), 0);
            tick();
        end
        chk("t25_count_held", int'(match_count), 1);
        match_ready = 1'b1;
        cyc = 0;
        while (!dct_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("t25_resume_wait", cyc, 1);
        tick();
        dct_valid = 1'b0;
        dct_last  = 1'b0;
        wait_done("t25_done_latency", 2);
        chk("t25_match_count", int'(match_count), 2);

        // Entry counter saturation and overflow flag.
        do_start();
        send_obs(8'h05);
        for (int i = 0; i < 17; i++) send_entry(8'h00, 1'b0);
        send_entry(8'h05, 1'b1);
        wait_done("t26_done_latency", 2);
        chk("t26_idx_ovf", int'(idx_ovf), 1);
        chk("t26_match_count", int'(match_count), 1);

        // Asynchronous abort with a pending match.
        match_ready = 1'b0;
        do_start();
        send_obs(8'h05);
        send_entry(8'h05, 1'b0);
        chk("t27_match_pending", int'(match_valid), 1);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t27_match_valid", int'(match_valid), 0);
        chk("t27_match_idx", int'(match_idx), 0);
        chk("t27_busy", int'(busy), 0);
        chk("t27_dct_ready", int'(dct_ready), 0);
        chk("t27_obs_ready", int'(obs_ready), 0);
        chk("t27_match_count", int'(match_count), 0);
        chk("t27_idx_ovf", int'(idx_ovf), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t27_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        match_ready = 1'b1;
        tick();
        chk("t27_no_done_after", int'(done), 0);
        do_start();
        send_obs(8'hA0);
        send_entry(8'hA0, 1'b1);
        wait_done("t27_redo_done_latency", 2);
        chk("t27_redo_count", int'(match_count), 1);

        // start and obs_valid pulsed during SCAN are ignored.
        do_start();
        send_obs(8'h05);
        start     = 1'b1;
        obs_valid = 1'b1;
        obs_fail  = 1'b1;
        tick();
        start     = 1'b0;
        obs_valid = 1'b0;
        obs_fail  = 1'b0;
        chk("t28_busy", int'(busy), 1);
        chk("t28_dct_ready", int'(dct_ready), 1);
        chk("t28_obs_ready", int'(obs_ready), 0);
        send_entry(8'h05, 1'b1);
        wait_done("t28_done_latency", 2);
        chk("t28_match_count", int'(match_count), 1);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
